wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_stage_if.sv | 28 ++
 rtl/wb_stage_load_ext.sv | 37 +++
 rtl/wb_stage.sv | 70 +++++++
 tb/tb_wb_stage.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared constants and register layout for the write-back stage.
package wb_pkg;

  localparam logic [1:0] WBSEL_MEM = 2'b00;
  localparam logic [1:0] WBSEL_ALU = 2'b01;
  localparam logic [1:0] WBSEL_PC4 = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rdata;
  } memwb_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB pipeline bus: MEM-stage inputs, stage-5 decoder inputs and WB outputs.
interface wb_stage_if;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic [31:0] inst_m;
  logic [31:0] pc_m;
  logic [31:0] alu_m;
  logic [31:0] dmem_rdata;
  logic [1:0]  wbsel_w;
  logic        regwen_w;
  logic [31:0] inst_w;
  logic        valid_w;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        rd_we;
  logic [63:0] instret;

  modport master (
    output stall, flush, in_valid, inst_m, pc_m, alu_m, dmem_rdata, wbsel_w, regwen_w,
    input  inst_w, valid_w, rd_addr, rd_wdata, rd_we, instret
  );

  modport slave (
    input  stall, flush, in_valid, inst_m, pc_m, alu_m, dmem_rdata, wbsel_w, regwen_w,
    output inst_w, valid_w, rd_addr, rd_wdata, rd_we, instret
  );
endinterface

// File: rtl/wb_stage_load_ext.sv
// Byte/halfword select and sign/zero extension of an aligned load word.
module load_ext
  import wb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    value = word;
    case (funct3)
      F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  value = {24'h000000, byte_sel};
      F3_LH:   value = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  value = {16'h0000, half_sel};
      F3_LW:   value = word;
      default: value = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, write-back mux and retired-instruction counter.
// WB_LOAD_EXT_EN: when defined, loads are byte/half extended via load_ext.
module wb_stage
  import wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  bus
);

  memwb_t      r;
  logic [63:0] instret_q;
  logic [31:0] load_val;
  logic [4:0]  rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r.valid   <= 1'b0;
      r.inst    <= NOP_INST;
      r.pc      <= '0;
      r.alu     <= '0;
      r.rdata   <= '0;
      instret_q <= '0;
    end else begin
      // flush retires the slot even while stalled, so it bypasses stall gating
      if (r.valid && (!bus.stall || bus.flush))
        instret_q <= instret_q + 64'd1;
      if (bus.flush) begin
        r.valid <= 1'b0;
        r.inst  <= NOP_INST;
      end else if (!bus.stall) begin
        r.valid <= bus.in_valid;
        r.inst  <= bus.inst_m;
        r.pc    <= bus.pc_m;
        r.alu   <= bus.alu_m;
        r.rdata <= bus.dmem_rdata;
      end
    end
  end

`ifdef WB_LOAD_EXT_EN
  load_ext u_load_ext (
    .word   (r.rdata),
    .offset (r.alu[1:0]),
    .funct3 (r.inst[14:12]),
    .value  (load_val)
  );
`else
  assign load_val = r.rdata;
`endif

  assign rd = r.inst[11:7];

  always_comb begin
    bus.rd_wdata = r.alu;
    case (bus.wbsel_w)
      WBSEL_MEM: bus.rd_wdata = load_val;
      WBSEL_ALU: bus.rd_wdata = r.alu;
      WBSEL_PC4: bus.rd_wdata = r.pc + 32'd4;
      default:   bus.rd_wdata = r.alu;
    endcase
  end

  assign bus.inst_w  = r.inst;
  assign bus.valid_w = r.valid;
  assign bus.rd_addr = rd;
  assign bus.rd_we   = r.valid & bus.regwen_w & (rd != 5'd0);
  assign bus.instret = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes model predictions, a monitor pops and compares.
module tb_wb_stage;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_stage_if bus();

  wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic [4:0]  rd;
    bit          wd_known;
    logic [31:0] wdata;
    logic        we;
    logic [63:0] instret;
    bit          kw;
    logic [31:0] kwd;
    bit          ke;
    logic        kwe;
  } exp_t;

  exp_t        q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          active = 0;

  logic        m_valid;
  logic [31:0] m_inst, m_pc, m_alu, m_rdata;
  bit          m_known;
  logic [63:0] m_ret;

  function automatic logic [31:0] load_ref(logic [31:0] w, logic [1:0] off, logic [2:0] f3);
    int unsigned b, h;
    b = (w >> (8 * int'(off))) & 32'hFF;
    h = (w >> (16 * int'(off[1]))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128)   ? b - 256   : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] wdata_ref(logic [1:0] ws);
    case (ws)
`ifdef WB_LOAD_EXT_EN
      2'd0:    return load_ref(m_rdata, m_alu[1:0], m_inst[14:12]);
`else
      2'd0:    return m_rdata;
`endif
      2'd2:    return m_pc + 32'd4;
      default: return m_alu;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit f, input bit v,
                      input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] alu, input logic [31:0] rdat,
                      input logic [1:0] ws, input bit rw,
                      input bit kw, input logic [31:0] kwd, input bit ke, input bit kwe);
    exp_t e;
    @(negedge clk);
    rst            = r;
    bus.stall      = s;
    bus.flush      = f;
    bus.in_valid   = v;
    bus.inst_m     = inst;
    bus.pc_m       = pc;
    bus.alu_m      = alu;
    bus.dmem_rdata = rdat;
    bus.wbsel_w    = ws;
    bus.regwen_w   = rw;
    if (r) begin
      m_valid = 1'b0; m_inst = NOP_INST; m_pc = '0; m_alu = '0; m_rdata = '0;
      m_known = 1'b1; m_ret = '0;
    end else begin
      if (m_valid && (!s || f)) m_ret = m_ret + 64'd1;
      if (f) begin
        m_valid = 1'b0; m_inst = NOP_INST; m_known = 1'b0;
      end else if (!s) begin
        m_valid = v; m_inst = inst; m_pc = pc; m_alu = alu; m_rdata = rdat;
        m_known = 1'b1;
      end
    end
    e.valid    = m_valid;
    e.inst     = m_inst;
    e.rd       = m_inst[11:7];
    e.wd_known = m_known;
    e.wdata    = wdata_ref(ws);
    e.we       = m_valid && rw && (m_inst[11:7] != 5'd0);
    e.instret  = m_ret;
    e.kw       = kw;
    e.kwd      = kwd;
    e.ke       = ke;
    e.kwe      = kwe;
    q.push_back(e);
    active = 1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("valid_w", {63'd0, bus.valid_w}, {63'd0, e.valid});
        chk("inst_w", {32'd0, bus.inst_w}, {32'd0, e.inst});
        chk("rd_addr", {59'd0, bus.rd_addr}, {59'd0, e.rd});
        chk("rd_we", {63'd0, bus.rd_we}, {63'd0, e.we});
        chk("instret", bus.instret, e.instret);
        if (e.wd_known) chk("rd_wdata", {32'd0, bus.rd_wdata}, {32'd0, e.wdata});
        if (e.kw) chk("rd_wdata_const", {32'd0, bus.rd_wdata}, {32'd0, e.kwd});
        if (e.ke) chk("rd_we_const", {63'd0, bus.rd_we}, {63'd0, e.kwe});
      end else if (active) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underflow: got empty queue want an expectation");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] lb_exp, lbu_exp;

  initial begin
`ifdef WB_LOAD_EXT_EN
    lb_exp  = 32'hFFFFFFAB;
    lbu_exp = 32'h000000AB;
`else
    lb_exp  = 32'h00AB0000;
    lbu_exp = 32'h00AB0000;
`endif
    // reset for two cycles, then release with no valid instruction
    step(1, 0, 0, 0, '0, '0, '0, '0, 2'd1, 1, 0, '0, 1, 0);
    step(1, 0, 0, 0, '0, '0, '0, '0, 2'd1, 1, 0, '0, 1, 0);
    step(0, 0, 0, 0, '0, '0, '0, '0, 2'd1, 1, 0, '0, 1, 0);

    // ADD x5 with ALU write-back
    step(0, 0, 0, 1, 32'h002082B3, 32'h00000100, 32'h12345678, 32'h0, 2'd1, 1, 1, 32'h12345678, 1, 1);

    // LB / LBU from byte offset 2
    step(0, 0, 0, 1, 32'h00000303, 32'h00000104, 32'h00001002, 32'h00AB0000, 2'd0, 1, 1, lb_exp, 1, 1);
    step(0, 0, 0, 1, 32'h00004303, 32'h00000108, 32'h00001002, 32'h00AB0000, 2'd0, 1, 1, lbu_exp, 1, 1);

    // JAL link value wraps; rd=x0 suppresses the write strobe
    step(0, 0, 0, 1, 32'h000000EF, 32'hFFFFFFFC, 32'h0, 32'h0, 2'd2, 1, 1, 32'h00000000, 1, 1);
    step(0, 0, 0, 1, 32'h0000006F, 32'hFFFFFFFC, 32'h0, 32'h0, 2'd2, 1, 1, 32'h00000000, 1, 0);

    // hold through three stalled cycles, then flush while stalled
    step(0, 0, 0, 1, 32'h002083B3, 32'h00000200, 32'hCAFE0001, 32'h0, 2'd1, 1, 1, 32'hCAFE0001, 1, 1);
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 1, $urandom, $urandom, $urandom, $urandom, 2'd1, 1, 1, 32'hCAFE0001, 1, 1);
    step(0, 1, 1, 1, $urandom, $urandom, $urandom, $urandom, 2'd1, 1, 0, '0, 1, 0);

    // reset arriving during a stalled valid load
    step(0, 0, 0, 1, 32'h00002403, 32'h00000300, 32'h00002000, 32'h55AA55AA, 2'd0, 1, 1, 32'h55AA55AA, 1, 1);
    step(0, 1, 0, 1, $urandom, $urandom, $urandom, $urandom, 2'd0, 1, 1, 32'h55AA55AA, 1, 1);
    step(1, 1, 0, 1, $urandom, $urandom, $urandom, $urandom, 2'd0, 1, 0, '0, 1, 0);

    for (int i = 0; i < 500; i++) begin
      logic [31:0] ri, rpc;
      ri  = $urandom;
      rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : $urandom;
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
           ri, rpc, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           0, '0, 0, 0);
    end

    @(posedge clk);
    #2;
    active = 0;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
